cus19_pc_unit: RTL
==================

// Module: cus19_pc_unit
// PURPOSE
//  Program-counter stage of the Custom19 core. Consumes pc_src from cus19_branch_unit
//  and the decoded offset/target, and registers the next fetch address.
//  Holds a small return-address stack (RAS) for CALL/RET.
//  Drives instruction-memory address and a one-cycle redirect pulse that the fetch/decode
//  pipeline uses to flush.
// PARAMETERS
//  PC_W        20   program-counter / instruction-address width (bits)
//  OFF_W       12   branch offset width, two's complement, sign-extended to PC_W
//  RAS_DEPTH   4    return-address stack entries (power of 2, >=2)
//  RESET_VEC   0    PC value loaded on reset
// PORTS
//  clk_in            in   1          core clock, all state on rising edge
//  rst_in            in   1          asynchronous, active-high reset
//  stall_in          in   1          1 = hold PC, RAS and flags; pc_src_in ignored
//  pc_src_in         in   3          next-PC select from branch unit (encoding below)
//  branch_off_in     in   OFF_W      signed PC-relative offset (BER/BNE)
//  jump_addr_in      in   PC_W       absolute target (JMP/CALL)
//  pc_out            out  PC_W       current fetch address (registered)
//  pc_plus1_out      out  PC_W       pc_out+1 mod 2^PC_W (combinational)
//  redirect_out      out  1          registered; 1 for one cycle after a non-sequential update
//  ras_ovf_out       out  1          sticky: CALL pushed while RAS full
//  ras_unf_out       out  1          sticky: RET popped while RAS empty
//  illegal_src_out   out  1          sticky: reserved pc_src encoding seen while not stalled
// BEHAVIOUR
//  Reset (async, immediate): pc_out=RESET_VEC; RAS pointer and count=0; RAS contents don't-care;
//   redirect_out, ras_ovf_out, ras_unf_out, illegal_src_out = 0. Release is on any edge;
//   first update is on the first rising clk_in with rst_in low.
//  pc_src_in encoding (evaluated only when stall_in=0):
//   000 SEQ     next = pc+1
//   001 BRANCH  next = pc + sext(branch_off_in), where pc = current pc_out (the branch's own address)
//   010 JUMP    next = jump_addr_in
//   011 CALL    next = jump_addr_in; push pc+1 onto RAS
//   100 RET     next = top of RAS; pop
//   101-111     reserved: next = pc+1, set illegal_src_out, RAS untouched
//  All PC arithmetic is modulo 2^PC_W: 0xFFFFF+1 -> 0x00000; negative offsets wrap likewise.
//  Latency: pc_src_in sampled at edge N -> pc_out holds the new value after edge N (one cycle).
//  redirect_out: after edge N, equals 1 if codes 001-100 were applied at N, else 0.
//   A BRANCH with offset +1 still counts as a redirect. Stall forces redirect_out to 0.
//  RAS: circular LIFO, count saturates at RAS_DEPTH.
//   CALL when count==RAS_DEPTH: overwrite the oldest entry; count stays RAS_DEPTH; set ras_ovf_out.
//   RET when count==0: next = pc+1; set ras_unf_out; pointer and count unchanged.
//   Push and pop never occur in the same cycle, because pc_src selects exactly one of them.
//  Stall: pc_out, RAS, pointer, count and sticky flags hold; redirect_out=0.
//  Reset mid-operation: all state returns to reset values, including the RAS count. Sticky flags
//   clear only on reset.
//  No X propagation: reserved codes and an empty RET produce defined values.
// TESTING
//  1 Reset, then 3 clocks of SEQ -> pc_out 0,1,2,3; redirect_out stays 0.
//  2 At pc=0x00010: BRANCH off=-4 (0xFFC) -> pc=0x0000C, redirect_out=1 for exactly 1 cycle.
//    At pc=0xFFFFF: SEQ -> 0x00000.
//  3 At pc=0x00020: CALL 0x00100, then 3 SEQ, then RET -> pc=0x00021.
//    Then a second RET -> pc+1, ras_unf_out=1.
//  4 Five nested CALLs (RAS_DEPTH=4) at pcs A..E -> ras_ovf_out=1.
//    Then 4 RETs return E+1, D+1, C+1, B+1.
//  5 Assert stall_in=1 with pc_src_in=JUMP 0x00555 for 3 cycles -> pc_out, redirect_out and RAS
//    unchanged. On release, JUMP is applied.
//  6 pc_src_in=3'b110 -> pc+1, illegal_src_out=1.
//    Assert rst_in asynchronously between clock edges mid-CALL sequence -> all outputs return to
//    reset values immediately, before the next clock edge.

Source files
------------

// File: rtl/cus19_pc_unit.sv
// Custom19 program-counter stage: next-PC select, return-address stack,
// redirect pulse for the fetch/decode flush, and sticky error flags.
module cus19_pc_unit #(
    parameter int unsigned PC_W      = 20,
    parameter int unsigned OFF_W     = 12,
    parameter int unsigned RAS_DEPTH = 4,
    parameter int unsigned RESET_VEC = 0
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             stall_in,
    input  logic [2:0]       pc_src_in,
    input  logic [OFF_W-1:0] branch_off_in,
    input  logic [PC_W-1:0]  jump_addr_in,
    output logic [PC_W-1:0]  pc_out,
    output logic [PC_W-1:0]  pc_plus1_out,
    output logic             redirect_out,
    output logic             ras_ovf_out,
    output logic             ras_unf_out,
    output logic             illegal_src_out
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    localparam logic [2:0] SRC_SEQ  = 3'b000;
    localparam logic [2:0] SRC_BR   = 3'b001;
    localparam logic [2:0] SRC_JMP  = 3'b010;
    localparam logic [2:0] SRC_CALL = 3'b011;
    localparam logic [2:0] SRC_RET  = 3'b100;

    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W-1:0]  ras_q [RAS_DEPTH];
    logic [PC_W-1:0]  ras_d [RAS_DEPTH];
    logic [PTR_W-1:0] sp_q, sp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             redirect_q, redirect_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             ill_q, ill_d;

    logic [PC_W-1:0]  pc_plus1;
    logic [PC_W-1:0]  off_ext;
    logic [PTR_W-1:0] top_idx;

    assign pc_plus1 = pc_q + PC_W'(1);
    assign off_ext  = {{(PC_W-OFF_W){branch_off_in[OFF_W-1]}}, branch_off_in};
    // sp points at the next free slot; the newest entry sits just below it
    assign top_idx  = sp_q - PTR_W'(1);

    always_comb begin
        pc_d       = pc_q;
        ras_d      = ras_q;
        sp_d       = sp_q;
        cnt_d      = cnt_q;
        redirect_d = 1'b0;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        ill_d      = ill_q;
        if (!stall_in) begin
            case (pc_src_in)
                SRC_SEQ: pc_d = pc_plus1;
                SRC_BR: begin
                    pc_d       = pc_q + off_ext;
                    redirect_d = 1'b1;
                end
                SRC_JMP: begin
                    pc_d       = jump_addr_in;
                    redirect_d = 1'b1;
                end
                SRC_CALL: begin
                    // when full, the slot at sp holds the oldest entry
                    pc_d        = jump_addr_in;
                    redirect_d  = 1'b1;
                    ras_d[sp_q] = pc_plus1;
                    sp_d        = sp_q + PTR_W'(1);
                    if (cnt_q == CNT_FULL) ovf_d = 1'b1;
                    else cnt_d = cnt_q + CNT_W'(1);
                end
                SRC_RET: begin
                    redirect_d = 1'b1;
                    if (cnt_q != '0) begin
                        pc_d  = ras_q[top_idx];
                        sp_d  = top_idx;
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        pc_d  = pc_plus1;
                        unf_d = 1'b1;
                    end
                end
                default: begin
                    pc_d  = pc_plus1;
                    ill_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pc_q       <= PC_W'(RESET_VEC);
            for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
            sp_q       <= '0;
            cnt_q      <= '0;
            redirect_q <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            ill_q      <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            ras_q      <= ras_d;
            sp_q       <= sp_d;
            cnt_q      <= cnt_d;
            redirect_q <= redirect_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            ill_q      <= ill_d;
        end
    end

    assign pc_out          = pc_q;
    assign pc_plus1_out    = pc_plus1;
    assign redirect_out    = redirect_q;
    assign ras_ovf_out     = ovf_q;
    assign ras_unf_out     = unf_q;
    assign illegal_src_out = ill_q;

endmodule
